// File: rtl/divider_result_collector_pkg.sv
// Shared widths and result types for the pipelined restoring divider.
// Imported by the result collector and by anything that consumes its results.
package divider_pkg;

  localparam int DEFAULT_DIVIDEND_WIDTH = 8;
  localparam int DEFAULT_DIVIDER_WIDTH  = 8;
  localparam int EXPAND_WIDTH           = 2 * DEFAULT_DIVIDEND_WIDTH;

  // Result as seen by the front end: quotient in the LSBs, flag on top.
  typedef struct packed {
    logic                              div_zero;
    logic [DEFAULT_DIVIDER_WIDTH-1:0]  remainder;
    logic [DEFAULT_DIVIDEND_WIDTH-1:0] quotient;
  } div_result_t;

  // One entry of the valid/flag delay line running beside the comparators.
  typedef struct packed {
    logic valid;
    logic div_zero;
  } tag_t;

endpackage

// File: rtl/divider_result_collector_fifo.sv
// First-word-fall-through result buffer with wrap-bit pointers and occupancy.
// Head data is read combinationally from registered storage and pointers.
module divider_result_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 16
) (
  input  logic                   in_clk,
  input  logic                   in_rst_n,
  input  logic                   in_wr_en,
  input  logic [WIDTH-1:0]       in_wr_data,
  input  logic                   in_rd_en,
  output logic [WIDTH-1:0]       out_rd_data,
  output logic                   out_empty,
  output logic                   out_full,
  output logic [$clog2(DEPTH):0] out_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;

  // NOTE: storage has no reset; the pointers alone define which entries are live.
  always_ff @(posedge in_clk) begin
    if (in_wr_en) begin
      mem[wr_ptr_q[AW-1:0]] <= in_wr_data;
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (in_wr_en) begin
        wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      end
      if (in_rd_en) begin
        rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
    end
  end

  // Equal pointers mean empty; differing only in the wrap bit means full.
  assign out_empty   = (wr_ptr_q == rd_ptr_q);
  assign out_full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign out_count   = wr_ptr_q - rd_ptr_q;
  assign out_rd_data = mem[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/divider_result_collector.sv
// Output stage of the pipelined restoring divider: tag delay line, result
// capture into a FWFT buffer, valid/ready output and issue credits.
module divider_result_collector
  import divider_pkg::*;
#(
  parameter int DIVIDEND_WIDTH = DEFAULT_DIVIDEND_WIDTH,
  parameter int DIVIDER_WIDTH  = DEFAULT_DIVIDER_WIDTH,
  parameter int PIPE_LATENCY   = 8,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic                          in_clk,
  input  logic                          in_rst_n,
  input  logic                          in_issue,
  input  logic                          in_issue_div_zero,
  output logic                          out_issue_ready,
  input  logic [2*DIVIDEND_WIDTH-1:0]   in_final_dividend_expand,
  output logic                          out_valid,
  input  logic                          in_ready,
  output logic [DIVIDEND_WIDTH-1:0]     out_quotient,
  output logic [DIVIDER_WIDTH-1:0]      out_remainder,
  output logic                          out_div_zero,
  output logic [$clog2(FIFO_DEPTH):0]   out_fifo_count
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic                      div_zero;
    logic [DIVIDER_WIDTH-1:0]  remainder;
    logic [DIVIDEND_WIDTH-1:0] quotient;
  } entry_t;

  tag_t             tag_q [PIPE_LATENCY];
  logic [CNT_W-1:0] credit_q;
  logic             issue_accept;
  logic             pop;
  logic             capture;
  logic             fifo_empty;
  logic             fifo_full;
  entry_t           wr_entry;
  entry_t           head_entry;

  // Credits cover both in-flight tags and buffered results, so a capture can
  // never find the buffer full while the pipeline is free-running.
  assign out_issue_ready = (credit_q != CNT_W'(FIFO_DEPTH));
  assign issue_accept    = in_issue && out_issue_ready;
  assign pop             = out_valid && in_ready;
  assign capture         = tag_q[PIPE_LATENCY-1].valid;

  // NOTE: every register stage uses <= so all stages shift on the same edge.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      for (int i = 0; i < PIPE_LATENCY; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0].valid    <= issue_accept;
      tag_q[0].div_zero <= in_issue_div_zero;
      for (int i = 1; i < PIPE_LATENCY; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      credit_q <= '0;
    end else begin
      case ({issue_accept, pop})
        2'b10:   credit_q <= credit_q + CNT_W'(1);
        2'b01:   credit_q <= credit_q - CNT_W'(1);
        default: credit_q <= credit_q;
      endcase
    end
  end

  // NOTE: defaults first so no path through this block can infer a latch.
  always_comb begin
    wr_entry           = '0;
    wr_entry.quotient  = in_final_dividend_expand[DIVIDEND_WIDTH-1:0];
    wr_entry.remainder = in_final_dividend_expand[DIVIDEND_WIDTH +: DIVIDER_WIDTH];
    wr_entry.div_zero  = tag_q[PIPE_LATENCY-1].div_zero;
  end

  divider_result_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .in_clk      (in_clk),
    .in_rst_n    (in_rst_n),
    .in_wr_en    (capture),
    .in_wr_data  (wr_entry),
    .in_rd_en    (pop),
    .out_rd_data (head_entry),
    .out_empty   (fifo_empty),
    .out_full    (fifo_full),
    .out_count   (out_fifo_count)
  );

  // Unwritten storage is never shown: the head is masked whenever nothing is buffered.
  always_comb begin
    out_valid     = !fifo_empty;
    out_quotient  = '0;
    out_remainder = '0;
    out_div_zero  = 1'b0;
    if (out_valid) begin
      out_quotient  = head_entry.quotient;
      out_remainder = head_entry.remainder;
      out_div_zero  = head_entry.div_zero;
    end
  end

  // Full is only reachable once every credit has become a buffered result.
  logic unused_full;
  assign unused_full = fifo_full;

endmodule
